// File: rtl/kzg_grad_stream.sv
// Streaming kernel-gradient unit: diff -> |diff| request, aligned multiply by kern_d1, optional group sum.
// One beat per cycle, result KERNEL_LAT+1 cycles after acceptance, no backpressure.
module kzg_grad_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 32,
  parameter int FRAC       = 16,
  parameter int KERNEL_LAT = 22,
  parameter int ACC_MODE   = 0,
  parameter int SAT_EN     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic                         in_last,
  input  logic signed [DATA_WIDTH-1:0] ori_x,
  input  logic signed [DATA_WIDTH-1:0] ori_y,
  input  logic signed [DATA_WIDTH-1:0] ori_z,
  input  logic signed [DATA_WIDTH-1:0] normalize_x,
  input  logic signed [DATA_WIDTH-1:0] normalize_y,
  input  logic signed [DATA_WIDTH-1:0] normalize_z,
  output logic                         mag_valid,
  output logic [DATA_WIDTH:0]          mag_x,
  output logic [DATA_WIDTH:0]          mag_y,
  output logic [DATA_WIDTH:0]          mag_z,
  input  logic signed [31:0]           kern_d1,
  input  logic                         ovf_clr,
  output logic                         out_valid,
  output logic                         out_last,
  output logic signed [OUT_WIDTH-1:0]  K_ZGx,
  output logic signed [OUT_WIDTH-1:0]  K_ZGy,
  output logic signed [OUT_WIDTH-1:0]  K_ZGz,
  output logic                         ovf
);

  localparam int DW1 = DATA_WIDTH + 1;
  localparam int PW  = 33 + DATA_WIDTH;
  localparam int AW  = OUT_WIDTH + 8;
  localparam int SW  = ((AW > PW) ? AW : PW) + 1;
  localparam logic signed [SW-1:0] MAXV = {{(SW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = ~MAXV;

  logic signed [DATA_WIDTH-1:0] ori [3];
  logic signed [DATA_WIDTH-1:0] nrm [3];
  logic signed [DW1-1:0]        diff [3];
  logic [DW1-1:0]               mag [3];

  assign ori[0] = ori_x;
  assign ori[1] = ori_y;
  assign ori[2] = ori_z;
  assign nrm[0] = normalize_x;
  assign nrm[1] = normalize_y;
  assign nrm[2] = normalize_z;

  always_comb begin
    for (int c = 0; c < 3; c++) begin
      diff[c] = {ori[c][DATA_WIDTH-1], ori[c]} - {nrm[c][DATA_WIDTH-1], nrm[c]};
      mag[c]  = diff[c][DW1-1] ? DW1'(-diff[c]) : DW1'(diff[c]);
    end
  end

  assign mag_valid = in_valid;
  assign mag_x     = mag[0];
  assign mag_y     = mag[1];
  assign mag_z     = mag[2];

  // Data taps carry no reset; only the qualifiers below decide what is live.
  logic signed [DW1-1:0] dly [KERNEL_LAT][3];
  always_ff @(posedge clk) begin
    for (int c = 0; c < 3; c++) begin
      dly[0][c] <= diff[c];
      for (int i = 1; i < KERNEL_LAT; i++) dly[i][c] <= dly[i-1][c];
    end
  end

  logic [KERNEL_LAT-1:0] vld_sr;
  logic [KERNEL_LAT-1:0] last_sr;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_sr  <= '0;
      last_sr <= '0;
    end else begin
      vld_sr[0]  <= in_valid;
      last_sr[0] <= in_last;
      for (int i = 1; i < KERNEL_LAT; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        last_sr[i] <= last_sr[i-1];
      end
    end
  end

  logic d_vld, d_last, emit;
  assign d_vld  = vld_sr[KERNEL_LAT-1];
  assign d_last = last_sr[KERNEL_LAT-1];
  assign emit   = d_vld & ((ACC_MODE == 0) | d_last);

  logic signed [AW-1:0]        acc  [3];
  logic signed [PW-1:0]        prod [3];
  logic signed [SW-1:0]        pext [3];
  logic signed [SW-1:0]        aext [3];
  logic signed [SW-1:0]        sum  [3];
  logic [OUT_WIDTH-1:0]        res  [3];
  logic [2:0]                  oor;
  logic signed [OUT_WIDTH-1:0] kzg  [3];

  // acc is never loaded in per-beat mode, so sum reduces to the bare product there.
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      prod[c] = kern_d1 * dly[KERNEL_LAT-1][c];
      pext[c] = prod[c] >>> FRAC;
      aext[c] = acc[c];
      sum[c]  = aext[c] + pext[c];
      oor[c]  = (sum[c] > MAXV) || (sum[c] < MINV);
      if (SAT_EN != 0 && sum[c] > MAXV)      res[c] = MAXV[OUT_WIDTH-1:0];
      else if (SAT_EN != 0 && sum[c] < MINV) res[c] = MINV[OUT_WIDTH-1:0];
      else                                   res[c] = sum[c][OUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 3; c++) begin
        acc[c] <= '0;
        kzg[c] <= '0;
      end
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= emit;
      out_last  <= emit & d_last;
      for (int c = 0; c < 3; c++) begin
        if (emit) kzg[c] <= res[c];
        if (ACC_MODE != 0 && d_vld) acc[c] <= d_last ? '0 : sum[c][AW-1:0];
      end
      if (emit && |oor) ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  assign K_ZGx = kzg[0];
  assign K_ZGy = kzg[1];
  assign K_ZGz = kzg[2];

endmodule

// File: tb/tb_kzg_grad_stream.sv
// Bench for kzg_grad_stream: three parameterisations share one stimulus stream and are
// compared cycle by cycle against a beat-level arithmetic model.
module tb_kzg_grad_stream;
  localparam int KL   = 22;
  localparam int MAXC = 128;
  localparam longint LMAX = 64'sd2147483647;
  localparam longint LMIN = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic in_valid = 1'b0, in_last = 1'b0, ovf_clr = 1'b0;
  logic signed [15:0] ori_x = '0, ori_y = '0, ori_z = '0;
  logic signed [15:0] normalize_x = '0, normalize_y = '0, normalize_z = '0;
  logic signed [31:0] kern_d1 = '0;

  logic [2:0]             mv_o, ov_o, ol_o, ovf_o;
  logic [2:0][2:0][16:0]  mag_o;
  logic [2:0][2:0][31:0]  k_o;

  int acc_mode [3] = '{0, 1, 1};
  int sat_en   [3] = '{1, 1, 0};

  for (genvar g = 0; g < 3; g++) begin : g_dut
    kzg_grad_stream #(
      .ACC_MODE((g == 0) ? 0 : 1),
      .SAT_EN((g == 2) ? 0 : 1)
    ) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
      .ori_x(ori_x), .ori_y(ori_y), .ori_z(ori_z),
      .normalize_x(normalize_x), .normalize_y(normalize_y), .normalize_z(normalize_z),
      .mag_valid(mv_o[g]), .mag_x(mag_o[g][0]), .mag_y(mag_o[g][1]), .mag_z(mag_o[g][2]),
      .kern_d1(kern_d1), .ovf_clr(ovf_clr),
      .out_valid(ov_o[g]), .out_last(ol_o[g]),
      .K_ZGx(k_o[g][0]), .K_ZGy(k_o[g][1]), .K_ZGz(k_o[g][2]), .ovf(ovf_o[g])
    );
  end

  int errs = 0;
  int checks = 0;

  // Stimulus table, one entry per cycle; bk is the kernel answer for the beat of that cycle.
  logic    bv [MAXC];
  logic    bl [MAXC];
  logic    bclr [MAXC];
  shortint bo [MAXC][3];
  shortint bn [MAXC][3];
  int      bk [MAXC];

  task automatic clear_stim();
    for (int c = 0; c < MAXC; c++) begin
      bv[c] = 1'b0; bl[c] = 1'b0; bclr[c] = 1'b0; bk[c] = 0;
      for (int k = 0; k < 3; k++) begin bo[c][k] = 0; bn[c][k] = 0; end
    end
  endtask

  function automatic logic [31:0] fmt(longint s, int sat);
    logic [31:0] r;
    r = s[31:0];
    if (sat != 0 && s > LMAX) r = 32'h7FFF_FFFF;
    if (sat != 0 && s < LMIN) r = 32'h8000_0000;
    return r;
  endfunction

  task automatic run_seq(input int ncyc, input int rc, input string tag);
    longint      acc [3][3];
    logic [31:0] ek  [3][3];
    logic        eov [3];
    logic        ev  [3];
    logic        el  [3];
    longint      p   [3];
    longint      s, m;
    int          t;
    logic        beat, setf;
    for (int i = 0; i < 3; i++) begin
      eov[i] = 1'b0;
      for (int k = 0; k < 3; k++) begin acc[i][k] = 0; ek[i][k] = '0; end
    end
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; ovf_clr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      rst = (c == rc);
      in_valid = bv[c]; in_last = bl[c]; ovf_clr = bclr[c];
      ori_x = bo[c][0]; ori_y = bo[c][1]; ori_z = bo[c][2];
      normalize_x = bn[c][0]; normalize_y = bn[c][1]; normalize_z = bn[c][2];
      if (c >= KL && bv[c-KL]) kern_d1 = bk[c-KL];
      else kern_d1 = $urandom;
      for (int i = 0; i < 3; i++) begin ev[i] = 1'b0; el[i] = 1'b0; end
      if (rc >= 0 && (c == rc || c == rc + 1)) begin
        for (int i = 0; i < 3; i++) begin
          eov[i] = 1'b0;
          for (int k = 0; k < 3; k++) begin acc[i][k] = 0; ek[i][k] = '0; end
        end
      end else begin
        t = c - KL - 1;
        beat = (t >= 0) && bv[t] && !(rc >= 0 && t <= rc && c > rc);
        if (beat)
          for (int k = 0; k < 3; k++)
            p[k] = (longint'(bk[t]) * (longint'(bo[t][k]) - longint'(bn[t][k]))) >>> 16;
        for (int i = 0; i < 3; i++) begin
          setf = 1'b0;
          if (beat) begin
            if (acc_mode[i] == 0 || bl[t]) begin
              ev[i] = 1'b1; el[i] = bl[t];
              for (int k = 0; k < 3; k++) begin
                s = acc[i][k] + p[k];
                ek[i][k] = fmt(s, sat_en[i]);
                if (s > LMAX || s < LMIN) setf = 1'b1;
                acc[i][k] = 0;
              end
            end else begin
              for (int k = 0; k < 3; k++) acc[i][k] = acc[i][k] + p[k];
            end
          end
          if (setf) eov[i] = 1'b1;
          else if (c > 0 && bclr[c-1]) eov[i] = 1'b0;
        end
      end
      @(negedge clk);
      if (bv[c]) begin
        checks++;
        if (mv_o[0] !== 1'b1) begin
          errs++; $display("FAIL %s mag_valid c=%0d got=%b want=1", tag, c, mv_o[0]);
        end
        for (int k = 0; k < 3; k++) begin
          m = longint'(bo[c][k]) - longint'(bn[c][k]);
          if (m < 0) m = -m;
          checks++;
          if (mag_o[0][k] !== 17'(m)) begin
            errs++; $display("FAIL %s mag[%0d] c=%0d got=%0d want=%0d", tag, k, c, mag_o[0][k], m);
          end
        end
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (ov_o[i] !== ev[i]) begin
          errs++; $display("FAIL %s out_valid inst%0d c=%0d got=%b want=%b", tag, i, c, ov_o[i], ev[i]);
        end
        checks++;
        if (ol_o[i] !== el[i]) begin
          errs++; $display("FAIL %s out_last inst%0d c=%0d got=%b want=%b", tag, i, c, ol_o[i], el[i]);
        end
        checks++;
        if (ovf_o[i] !== eov[i]) begin
          errs++; $display("FAIL %s ovf inst%0d c=%0d got=%b want=%b", tag, i, c, ovf_o[i], eov[i]);
        end
        for (int k = 0; k < 3; k++) begin
          checks++;
          if (k_o[i][k] !== ek[i][k]) begin
            errs++; $display("FAIL %s K[%0d] inst%0d c=%0d got=%h want=%h", tag, k, i, c, k_o[i][k], ek[i][k]);
          end
        end
      end
    end
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    in_valid = 1'b1; ori_x = 16'sd5; normalize_x = 16'sd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ov_o[i] !== 1'b0 || ol_o[i] !== 1'b0) begin
        errs++; $display("FAIL reset valid/last inst%0d got=%b%b want=00", i, ov_o[i], ol_o[i]);
      end
      checks++;
      if (ovf_o[i] !== 1'b0) begin
        errs++; $display("FAIL reset ovf inst%0d got=%b want=0", i, ovf_o[i]);
      end
      checks++;
      if (k_o[i] !== '0) begin
        errs++; $display("FAIL reset K inst%0d got=%h want=0", i, k_o[i]);
      end
    end
    checks++;
    if (mv_o[0] !== 1'b1 || mag_o[0][0] !== 17'd5) begin
      errs++; $display("FAIL reset mag comb got=%b/%0d want=1/5", mv_o[0], mag_o[0][0]);
    end
    in_valid = 1'b0; ori_x = '0;
  endtask

  task automatic test_single();
    clear_stim();
    bv[0] = 1'b1; bl[0] = 1'b1; bo[0][0] = 16'sh0100; bk[0] = 32'h0001_0000;
    run_seq(30, -1, "single");
    checks++;
    if (k_o[0][0] !== 32'd256 || k_o[0][1] !== 32'd0 || k_o[0][2] !== 32'd0) begin
      errs++; $display("FAIL single held K got=%h want=256,0,0", k_o[0]);
    end
  endtask

  task automatic test_extreme();
    clear_stim();
    bv[0] = 1'b1; bl[0] = 1'b1; bo[0][0] = -16'sd32768; bn[0][0] = 16'sd32767;
    bk[0] = 32'hFFFF_0000;
    run_seq(28, -1, "extreme");
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (k_o[i][0] !== 32'd65535) begin
        errs++; $display("FAIL extreme K_ZGx inst%0d got=%0d want=65535", i, k_o[i][0]);
      end
    end
  endtask

  task automatic test_accum();
    clear_stim();
    for (int c = 0; c < 4; c++) begin
      bv[c] = 1'b1; bo[c][0] = 16'sd256; bk[c] = 32'h0001_0000;
    end
    bl[2] = 1'b1; bl[3] = 1'b1;
    run_seq(30, -1, "accum");
    checks++;
    if (k_o[1][0] !== 32'd256) begin
      errs++; $display("FAIL accum next group got=%0d want=256", k_o[1][0]);
    end
  endtask

  task automatic test_overflow();
    clear_stim();
    for (int c = 0; c < 2; c++) begin
      bv[c] = 1'b1; bo[c][0] = 16'sd32767; bn[c][0] = -16'sd32768; bk[c] = 32'h7FFF_FFFF;
    end
    bl[1] = 1'b1;
    bclr[23] = 1'b1;
    bclr[27] = 1'b1;
    run_seq(32, -1, "overflow");
    checks++;
    if (k_o[1][0] !== 32'h7FFF_FFFF) begin
      errs++; $display("FAIL overflow sat got=%h want=7fffffff", k_o[1][0]);
    end
    checks++;
    if (k_o[2][0] !== 32'hFFFE_FFFE) begin
      errs++; $display("FAIL overflow wrap got=%h want=fffefffe", k_o[2][0]);
    end
  endtask

  task automatic test_back_to_back();
    clear_stim();
    for (int c = 0; c < 50; c++) begin
      bv[c] = 1'b1;
      bl[c] = ($urandom_range(0, 3) == 0);
      bclr[c] = ($urandom_range(0, 15) == 0);
      bk[c] = $urandom;
      for (int k = 0; k < 3; k++) begin
        bo[c][k] = shortint'($urandom);
        bn[c][k] = shortint'($urandom);
      end
    end
    bl[49] = 1'b1;
    run_seq(50 + KL + 4, -1, "stream");
  endtask

  task automatic test_reset_mid_group();
    clear_stim();
    for (int c = 0; c < 5; c++) begin
      bv[c] = 1'b1; bo[c][0] = 16'sd1000; bk[c] = 32'h7FFF_FFFF;
    end
    bv[12] = 1'b1; bl[12] = 1'b1;
    bk[12] = $urandom;
    for (int k = 0; k < 3; k++) begin
      bo[12][k] = shortint'($urandom);
      bn[12][k] = shortint'($urandom);
    end
    run_seq(12 + KL + 5, 10, "rstmid");
  endtask

  initial begin
    test_reset();
    test_single();
    test_extreme();
    test_accum();
    test_overflow();
    test_back_to_back();
    test_reset_mid_group();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/kzg_grad_stream.md
KZG_GRAD_STREAM -- requirements
Module: kzg_grad_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning the width of the signed coordinate inputs.
REQ-002 SHALL have parameter OUT_WIDTH, default 32, meaning the width of the signed gradient outputs (range 24..48).
REQ-003 SHALL have parameter FRAC, default 16, meaning the number of fractional bits of kern_d1; the product is shifted right arithmetically by FRAC.
REQ-004 SHALL have parameter KERNEL_LAT, default 22, meaning the cycles from mag_valid to the matching kern_d1 (range 1..64).
REQ-005 SHALL have parameter ACC_MODE, default 0: 0 = one output per input; 1 = sum over each group terminated by in_last.
REQ-006 SHALL have parameter SAT_EN, default 1: 1 = saturate to OUT_WIDTH; 0 = two's-complement wrap.
REQ-007 Ports, one per line:
 clk  in  1  rising-edge clock
 rst  in  1  asynchronous active-high reset
 in_valid  in  1  input beat qualifier
 in_last  in  1  group terminator (ACC_MODE=1 only)
 ori_x/ori_y/ori_z  in  DATA_WIDTH each  signed origin coordinates
 normalize_x/_y/_z  in  DATA_WIDTH each  signed neighbour coordinates
 mag_valid  out  1  request to the external magnitude/kernel unit
 mag_x/mag_y/mag_z  out  DATA_WIDTH+1 each  unsigned |diff|
 kern_d1  in  32  signed kernel derivative, Q(32-FRAC).FRAC
 ovf_clr  in  1  synchronous clear of ovf
 out_valid  out  1  result qualifier
 out_last  out  1  copy of in_last for the emitted beat
 K_ZGx/K_ZGy/K_ZGz  out  OUT_WIDTH each  signed gradient components
 ovf  out  1  sticky overflow flag

Function
REQ-008 diff_c SHALL be ori_c - normalize_c computed in DATA_WIDTH+1 signed bits with sign extension, so it never overflows.
REQ-009 mag_c SHALL be |diff_c| combinationally; mag_valid SHALL equal in_valid in the same cycle.
REQ-010 diff_x/y/z, in_valid and in_last SHALL be delayed by exactly KERNEL_LAT registers, so that they align with kern_d1 in cycle t+KERNEL_LAT for a beat accepted in cycle t.
REQ-011 kern_d1 SHALL be ignored in every cycle where the delayed valid is 0.
REQ-012 p_c SHALL be (kern_d1 * diff_c) >>> FRAC using full-precision signed arithmetic (33+DATA_WIDTH bits) before the shift.
REQ-013 With ACC_MODE=0, the block SHALL register the results of p_c to K_ZG_c, and SHALL assert out_valid and out_last at cycle t+KERNEL_LAT+1.
REQ-014 With ACC_MODE=1, the block SHALL keep one accumulator per component at OUT_WIDTH+8 bits, and SHALL add p_c on every delayed-valid beat.
REQ-015 With ACC_MODE=1, on a delayed-valid beat with last=1, the block SHALL output acc_c+p_c at the next edge with out_valid=out_last=1, and SHALL load the accumulators with 0 on that same edge.
REQ-016 With ACC_MODE=1, out_valid SHALL stay 0 on beats without last; a single-beat group with last=1 SHALL output p_c.
REQ-017 With SAT_EN=1, the block SHALL clamp each output to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; with SAT_EN=0, it SHALL keep only the low OUT_WIDTH bits.
REQ-018 ovf SHALL be set at the edge where any emitted component is out of OUT_WIDTH range, in either SAT_EN mode.
REQ-019 ovf SHALL stay set until ovf_clr or rst; if ovf_clr and a new overflow occur in the same cycle, the set SHALL win.
REQ-020 When out_valid=0, K_ZG_c SHALL hold their last values.
REQ-021 The block SHALL sustain one beat per cycle with no backpressure; back-to-back groups SHALL need no idle cycle.

Reset
REQ-022 rst SHALL asynchronously clear all delay-line valid/last bits, accumulators, out_valid, out_last, ovf and K_ZG_c to 0.
REQ-023 Diff data registers SHALL need no reset.
REQ-024 Beats in flight at reset SHALL be dropped; a partial group at reset SHALL be discarded and SHALL never be emitted.
REQ-025 The first beat after rst deasserts SHALL appear KERNEL_LAT+1 cycles after it is accepted.

Verification
REQ-026 Defaults, ori=(0x0100,0,0), norm=0, kern_d1=0x0001_0000 at t+22 -> mag_x=0x100 at t; K_ZGx=256, K_ZGy=K_ZGz=0; out_valid at t+23 only.
REQ-027 ori_x=-32768, normalize_x=32767 -> mag_x=65535; with kern_d1=0xFFFF_0000 (-1.0), K_ZGx=+65535.
REQ-028 ACC_MODE=1, three beats diff_x=256 with d1=1.0 and last on the third -> one output K_ZGx=768 with out_last=1; the next group starts from 0.
REQ-029 ACC_MODE=1, two beats with d1=0x7FFF_FFFF and diff_x=65535 -> K_ZGx=0x7FFF_FFFF and ovf=1; repeating with SAT_EN=0 gives the wrapped low 32 bits and ovf=1.
REQ-030 Streaming: 50 consecutive beats with random inputs -> 50 outputs, in order, each at its own t+23, all matching a reference model.
REQ-031 rst pulse mid-group at t+10 -> no output for the in-flight beats; ovf=0; a fresh beat after reset appears at its own acceptance cycle +23.
